// File: rtl/sp_ram_gen.sv
// Parametrised single-port RAM with byte-enabled writes, selectable write mode,
// optional output register, read-valid tracking and a clear sweep sequencer.
module sp_ram_gen #(
    parameter int                    ADDR_WIDTH     = 11,
    parameter int                    DATA_WIDTH     = 16,
    parameter int                    BE_WIDTH       = 2,
    parameter int                    WRITE_MODE     = 0,
    parameter int                    OUTPUT_REG     = 0,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    output logic                  busy,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  wr_en,
    input  logic [BE_WIDTH-1:0]   wr_byte_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    localparam int LW    = DATA_WIDTH / BE_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        IDLE     = 2'd1,
        CLEAR    = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   sweep_addr_q, sweep_addr_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [BE_WIDTH-1:0]     lane_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   old_word;
    logic [DATA_WIDTH-1:0]   merged_word;

    logic                    user_wr;
    logic                    user_rd;
    logic                    rd_valid1_q, rd_valid1_d;
    logic [DATA_WIDTH-1:0]   rd_data1_q, rd_data1_d;

    // The hold state before the first edge already counts as busy when a sweep will follow.
    assign busy = (state_q == CLEAR) || ((state_q == RST_HOLD) && (CLEAR_ON_RESET != 0));

    always_comb begin
        state_d      = state_q;
        sweep_addr_d = sweep_addr_q;
        case (state_q)
            RST_HOLD: state_d = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (sweep_addr_q == LAST_ADDR) begin
                    state_d      = IDLE;
                    sweep_addr_d = '0;
                end else begin
                    sweep_addr_d = sweep_addr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RST_HOLD;
            sweep_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            sweep_addr_q <= sweep_addr_d;
        end
    end

    // NORMAL mode suppresses the read half of a simultaneous read/write.
    always_comb begin
        user_wr = !busy && wr_en;
        user_rd = !busy && rd_en && (!wr_en || (WRITE_MODE != 0));
    end

    always_comb begin
        old_word    = mem[addr];
        merged_word = old_word;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (wr_byte_en[i]) begin
                merged_word[i*LW +: LW] = wr_data[i*LW +: LW];
            end
        end
    end

    always_comb begin
        if (state_q == CLEAR) begin
            lane_we   = '1;
            mem_addr  = sweep_addr_q;
            mem_wdata = CLEAR_VALUE;
        end else begin
            lane_we   = user_wr ? wr_byte_en : '0;
            mem_addr  = addr;
            mem_wdata = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (lane_we[i]) begin
                mem[mem_addr][i*LW +: LW] <= mem_wdata[i*LW +: LW];
            end
        end
    end

    always_comb begin
        rd_valid1_d = user_rd;
        rd_data1_d  = rd_data1_q;
        if (user_rd) begin
            rd_data1_d = ((WRITE_MODE == 1) && wr_en) ? merged_word : old_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid1_q <= 1'b0;
            rd_data1_q  <= '0;
        end else begin
            rd_valid1_q <= rd_valid1_d;
            rd_data1_q  <= rd_data1_d;
        end
    end

    generate
        if (OUTPUT_REG != 0) begin : g_oreg
            logic                  rd_valid2_q;
            logic [DATA_WIDTH-1:0] rd_data2_q, rd_data2_d;

            always_comb begin
                rd_data2_d = rd_valid1_q ? rd_data1_q : rd_data2_q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_valid2_q <= 1'b0;
                    rd_data2_q  <= '0;
                end else begin
                    rd_valid2_q <= rd_valid1_q;
                    rd_data2_q  <= rd_data2_d;
                end
            end

            assign rd_valid = rd_valid2_q;
            assign rd_data  = rd_data2_q;
        end else begin : g_noreg
            assign rd_valid = rd_valid1_q;
            assign rd_data  = rd_data1_q;
        end
    endgenerate

endmodule

// File: tb/tb_sp_ram_gen.sv
// Directed bench for sp_ram_gen: four instances (NORMAL, TRANSPARENT,
// READ_BEFORE_WRITE, NORMAL with output register) share one stimulus stream.
module tb_sp_ram_gen;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic [3:0]  addr;
    logic        wr_en;
    logic [1:0]  wr_byte_en;
    logic [15:0] wr_data;
    logic        rd_en;

    logic        bsy  [4];
    logic [15:0] rdat [4];
    logic        rval [4];

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sp_ram_gen #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BE_WIDTH(2), .WRITE_MODE(0), .OUTPUT_REG(0),
                 .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'hA5A5)) dut_normal (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(bsy[0]), .addr(addr), .wr_en(wr_en),
        .wr_byte_en(wr_byte_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rdat[0]), .rd_valid(rval[0]));

    sp_ram_gen #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BE_WIDTH(2), .WRITE_MODE(1), .OUTPUT_REG(0),
                 .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'hA5A5)) dut_transp (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(bsy[1]), .addr(addr), .wr_en(wr_en),
        .wr_byte_en(wr_byte_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rdat[1]), .rd_valid(rval[1]));

    sp_ram_gen #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BE_WIDTH(2), .WRITE_MODE(2), .OUTPUT_REG(0),
                 .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'hA5A5)) dut_rbw (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(bsy[2]), .addr(addr), .wr_en(wr_en),
        .wr_byte_en(wr_byte_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rdat[2]), .rd_valid(rval[2]));

    sp_ram_gen #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BE_WIDTH(2), .WRITE_MODE(0), .OUTPUT_REG(1),
                 .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'hA5A5)) dut_oreg (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(bsy[3]), .addr(addr), .wr_en(wr_en),
        .wr_byte_en(wr_byte_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rdat[3]), .rd_valid(rval[3]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_word(input int kind, input int k);
        return (kind == 0) ? 16'hA5A5 : (16'hFFFF - 16'(k));
    endfunction

    task automatic count_sweep(input string name);
        int cnt [4];
        for (int d = 0; d < 4; d++) cnt[d] = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            for (int d = 0; d < 4; d++) if (bsy[d] === 1'b1) cnt[d]++;
        end
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (cnt[d] !== 16 || bsy[d] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s dut%0d: busy cycles=%0d busy_end=%b, expected 16 and 0", name, d, cnt[d], bsy[d]);
            end
        end
    endtask

    task automatic read_all(input int kind, input string name);
        for (int k = 0; k < 16; k++) begin
            addr  = 4'(k);
            rd_en = 1'b1;
            wr_en = 1'b0;
            tick();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (rval[d] !== 1'b1 || rdat[d] !== exp_word(kind, k)) begin
                    errors++;
                    $display("[TB] FAIL %s dut%0d addr%0d: valid=%b data=%h, expected 1 %h", name, d, k, rval[d], rdat[d], exp_word(kind, k));
                end
            end
            if (k > 0) begin
                checks++;
                if (rval[3] !== 1'b1 || rdat[3] !== exp_word(kind, k - 1)) begin
                    errors++;
                    $display("[TB] FAIL %s dut3 addr%0d: valid=%b data=%h, expected 1 %h", name, k - 1, rval[3], rdat[3], exp_word(kind, k - 1));
                end
            end
        end
        rd_en = 1'b0;
        tick();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rval[d] !== 1'b0 || rdat[d] !== exp_word(kind, 15)) begin
                errors++;
                $display("[TB] FAIL %s_hold dut%0d: valid=%b data=%h, expected 0 %h", name, d, rval[d], rdat[d], exp_word(kind, 15));
            end
        end
        checks++;
        if (rval[3] !== 1'b1 || rdat[3] !== exp_word(kind, 15)) begin
            errors++;
            $display("[TB] FAIL %s dut3 addr15: valid=%b data=%h, expected 1 %h", name, rval[3], rdat[3], exp_word(kind, 15));
        end
        tick();
        checks++;
        if (rval[3] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_tail dut3: valid=%b, expected 0", name, rval[3]);
        end
    endtask

    task automatic write_word(input logic [3:0] a, input logic [15:0] data, input logic [1:0] be);
        addr       = a;
        wr_en      = 1'b1;
        rd_en      = 1'b0;
        wr_byte_en = be;
        wr_data    = data;
        tick();
        wr_en = 1'b0;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rval[d] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL write_only_valid dut%0d: valid=%b, expected 0", d, rval[d]);
            end
        end
    endtask

    task automatic read_one(input logic [3:0] a, input logic [15:0] expv, input string name);
        addr  = a;
        rd_en = 1'b1;
        wr_en = 1'b0;
        tick();
        rd_en = 1'b0;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rval[d] !== 1'b1 || rdat[d] !== expv) begin
                errors++;
                $display("[TB] FAIL %s dut%0d: valid=%b data=%h, expected 1 %h", name, d, rval[d], rdat[d], expv);
            end
        end
        tick();
        checks++;
        if (rval[3] !== 1'b1 || rdat[3] !== expv) begin
            errors++;
            $display("[TB] FAIL %s dut3: valid=%b data=%h, expected 1 %h", name, rval[3], rdat[3], expv);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_byte_en = 2'b00; wr_data = '0; addr = '0;
        #1 rst_n = 1'b0;
        #2;
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (rdat[d] !== 16'h0000 || rval[d] !== 1'b0 || bsy[d] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reset dut%0d: data=%h valid=%b busy=%b, expected 0000 0 1", d, rdat[d], rval[d], bsy[d]);
            end
        end
        tick();
        tick();
    endtask

    task automatic test_sweep_timing();
        @(negedge clk);
        rst_n = 1'b1;
        count_sweep("sweep_after_reset");
        read_all(0, "read_after_sweep");
    endtask

    task automatic test_write_read();
        for (int k = 0; k < 16; k++) write_word(4'(k), 16'hFFFF - 16'(k), 2'b11);
        read_all(1, "write_read");
    endtask

    task automatic test_byte_lanes();
        write_word(4'd3, 16'h1234, 2'b11);
        write_word(4'd3, 16'hABCD, 2'b01);
        read_one(4'd3, 16'h12CD, "byte_lane_low");
        write_word(4'd3, 16'h0000, 2'b00);
        read_one(4'd3, 16'h12CD, "byte_lane_none");
    endtask

    task automatic test_write_modes();
        write_word(4'd5, 16'h0001, 2'b11);
        read_one(4'd5, 16'h0001, "mode_preload");
        addr = 4'd5; wr_en = 1'b1; rd_en = 1'b1; wr_data = 16'h0002; wr_byte_en = 2'b11;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        checks++;
        if (rval[0] !== 1'b0 || rdat[0] !== 16'h0001) begin
            errors++;
            $display("[TB] FAIL mode_normal: valid=%b data=%h, expected 0 0001", rval[0], rdat[0]);
        end
        checks++;
        if (rval[1] !== 1'b1 || rdat[1] !== 16'h0002) begin
            errors++;
            $display("[TB] FAIL mode_transparent: valid=%b data=%h, expected 1 0002", rval[1], rdat[1]);
        end
        checks++;
        if (rval[2] !== 1'b1 || rdat[2] !== 16'h0001) begin
            errors++;
            $display("[TB] FAIL mode_read_before_write: valid=%b data=%h, expected 1 0001", rval[2], rdat[2]);
        end
        tick();
        checks++;
        if (rval[3] !== 1'b0 || rdat[3] !== 16'h0001) begin
            errors++;
            $display("[TB] FAIL mode_normal_oreg: valid=%b data=%h, expected 0 0001", rval[3], rdat[3]);
        end
        read_one(4'd5, 16'h0002, "mode_after_write");
    endtask

    task automatic test_clr();
        int cnt;
        cnt = 0;
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (bsy[d] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL clr_idle dut%0d: busy=%b, expected 0", d, bsy[d]);
            end
        end
        addr = 4'd2; wr_data = 16'h1111; wr_byte_en = 2'b11;
        for (int i = 0; i < 24; i++) begin
            clr   = (i == 0 || i == 4);
            wr_en = (i >= 6 && i <= 8);
            rd_en = (i >= 6 && i <= 8);
            tick();
            if (bsy[0] === 1'b1) cnt++;
            if (i >= 6 && i <= 8) begin
                for (int d = 0; d < 3; d++) begin
                    checks++;
                    if (rval[d] !== 1'b0 || rdat[d] !== 16'h0002) begin
                        errors++;
                        $display("[TB] FAIL clr_busy_access dut%0d: valid=%b data=%h, expected 0 0002", d, rval[d], rdat[d]);
                    end
                end
            end
        end
        clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        checks++;
        if (cnt !== 16) begin
            errors++;
            $display("[TB] FAIL clr_busy_len: busy cycles=%0d, expected 16", cnt);
        end
        read_all(0, "read_after_clr");
    endtask

    task automatic test_reset_mid_sweep();
        for (int k = 0; k < 16; k++) write_word(4'(k), 16'h5000 + 16'(k), 2'b11);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (rdat[d] !== 16'h0000 || rval[d] !== 1'b0 || bsy[d] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL mid_sweep_reset dut%0d: data=%h valid=%b busy=%b, expected 0000 0 1", d, rdat[d], rval[d], bsy[d]);
            end
        end
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        count_sweep("sweep_after_mid_reset");
        read_all(0, "read_after_mid_reset");
    endtask

    initial begin
        $display("[TB] starting sp_ram_gen bench");
        test_reset();
        test_sweep_timing();
        test_write_read();
        test_byte_lanes();
        test_write_modes();
        test_clr();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sp_ram_gen.md
Name: sp_ram_gen

Overview:
- Parametrised single-port RAM; successor to the fixed 11-bit × 16-bit single-port buffer in the vision pipeline.
- Adds the following over that buffer:
  - byte-enabled writes;
  - selectable write mode;
  - optional output register;
  - read-valid tracking;
  - a clear sequencer that sweeps the array after reset or on request. The array itself has no reset.
- Used as a line/feature buffer by downstream tracking logic.

Parameters:
- ADDR_WIDTH, 11, address bits; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 16, word width.
- BE_WIDTH, 2, byte-enable lanes. DATA_WIDTH must be divisible by BE_WIDTH. Lane width LW = DATA_WIDTH/BE_WIDTH.
- WRITE_MODE, 0: 0 = NORMAL, 1 = TRANSPARENT, 2 = READ_BEFORE_WRITE.
- OUTPUT_REG, 0: 1 adds one pipeline register on rd_data/rd_valid.
- CLEAR_ON_RESET, 1: 1 = run a clear sweep automatically after reset release.
- CLEAR_VALUE, 0: DATA_WIDTH-bit value written during a sweep.

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- clr, in, 1: single-cycle clear request.
- busy, out, 1: high while a sweep is running.
- addr, in, ADDR_WIDTH: access address.
- wr_en, in, 1: write strobe.
- wr_byte_en, in, BE_WIDTH: lane i enables bits [i*LW +: LW].
- wr_data, in, DATA_WIDTH: write word.
- rd_en, in, 1: read strobe.
- rd_data, out, DATA_WIDTH: read word.
- rd_valid, out, 1: rd_data is updated this cycle.

Behaviour:
- Reset (rst_n=0, async):
  - rd_data = 0, rd_valid = 0, including the output-register stage.
  - Sweep address = 0.
  - FSM = RST_HOLD; busy = CLEAR_ON_RESET.
  - Array contents are undefined and not reset.
- FSM states: IDLE, CLEAR.
  - RST_HOLD is the reset encoding. On the first clk edge after release: go to CLEAR if CLEAR_ON_RESET, else go to IDLE.
  - IDLE → CLEAR when clr=1. busy rises the cycle after clr is sampled.
  - CLEAR: each cycle writes CLEAR_VALUE to the sweep address, then increments the address.
  - At address 2**ADDR_WIDTH-1: write the last word, go to IDLE, reset the address to 0. busy falls on that same edge.
  - A full sweep takes exactly 2**ADDR_WIDTH cycles with busy=1.
  - clr during CLEAR is ignored; the sweep does not restart.
  - rst_n low mid-sweep aborts the sweep. After release the sweep restarts from address 0 (if CLEAR_ON_RESET).
- While busy=1: wr_en and rd_en are ignored (no array change from the user port), rd_valid = 0, rd_data holds.
- Write (IDLE, wr_en=1): at the clock edge, lanes with wr_byte_en[i]=1 take wr_data; other lanes keep their old contents. wr_byte_en = 0 writes nothing.
- Read (IDLE, rd_en=1, wr_en=0):
  - rd_data = mem[addr] after 1 edge (latency 1), or after 2 edges when OUTPUT_REG=1.
  - rd_valid is aligned with rd_data.
  - With no read, rd_data holds its last value and rd_valid = 0.
- wr_en=1 and rd_en=1 in the same cycle (same address, single port):
  - NORMAL: write only; rd_data holds; rd_valid = 0.
  - TRANSPARENT: rd_data = merged post-write word; rd_valid = 1.
  - READ_BEFORE_WRITE: rd_data = pre-write word; rd_valid = 1.
  - Latency is the same as for a plain read.
- wr_en=1 and rd_en=0: rd_valid = 0 in all modes.
- OUTPUT_REG=1 pipeline: both stages advance every cycle. rd_valid is the delayed strobe; the data stage loads only when the first stage is valid.
- Address range: no wrap logic on user addresses; every ADDR_WIDTH value is legal.

Test Plan (bench: ADDR_WIDTH=4, DATA_WIDTH=16, BE_WIDTH=2, CLEAR_VALUE=16'hA5A5):
- Sweep timing: release rst_n with CLEAR_ON_RESET=1 → busy high for exactly 16 cycles. Reading addresses 0..15 afterwards returns 16'hA5A5 each, with rd_valid one cycle after rd_en.
- Write then read: write addr k with 16'hFFFF-k for k=0..15 (byte_en=2'b11), then read 0..15 → rd_data = 16'hFFFF-k. Latency is 1 with OUTPUT_REG=0 and 2 with OUTPUT_REG=1; no rd_valid gaps.
- Byte lanes: write 16'h1234 to addr 3, then 16'hABCD with byte_en=2'b01 → read gives 16'h12CD. Then byte_en=2'b00 write → still 16'h12CD.
- Write modes: addr 5 holds 16'h0001; issue wr_en=rd_en=1 with 16'h0002:
  - NORMAL → rd_valid=0 and rd_data unchanged;
  - TRANSPARENT → 16'h0002;
  - READ_BEFORE_WRITE → 16'h0001.
  - In all three modes a subsequent read returns 16'h0002.
- clr mid-operation: pulse clr in IDLE → 16 busy cycles. A second clr 4 cycles in does not extend busy. A write issued during busy leaves the array at CLEAR_VALUE.
- Reset mid-sweep: assert rst_n=0 at sweep address 7 → rd_data=0, rd_valid=0 immediately. After release, busy is high for a full 16 cycles and all words read 16'hA5A5.
